// File: rtl/ws2812_rx.sv
// WS2812 one-wire receiver: decodes pulse widths into 24-bit GRB pixels,
// detects the latch gap and flags malformed frames.
module ws2812_rx #(
    parameter int BIT_THRESH   = 30,
    parameter int MAX_HIGH     = 100,
    parameter int RESET_CYCLES = 2500,
    parameter int CNT_W        = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [15:0] pixel_count,
    output logic        latch,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        ERR_WAIT
    } state_t;

    state_t             state_q;
    logic               s1_q, s2_q, sp_q;
    logic [CNT_W-1:0]   high_cnt_q, low_cnt_q;
    logic [4:0]         bit_cnt_q;
    logic [23:0]        shreg_q;
    logic               done_q, clr_q;
    logic [23:0]        pixel_data_q;
    logic               pixel_valid_q, latch_q, err_q;
    logic [15:0]        pixel_count_q;

    logic rise, fall, bit_d;

    always_comb begin
        rise  = s2_q & ~sp_q;
        fall  = ~s2_q & sp_q;
        bit_d = (high_cnt_q >= CNT_W'(BIT_THRESH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            sp_q          <= 1'b0;
            high_cnt_q    <= '0;
            low_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            done_q        <= 1'b0;
            clr_q         <= 1'b0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            pixel_count_q <= '0;
            latch_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            s1_q          <= din;
            s2_q          <= s1_q;
            sp_q          <= s2_q;
            pixel_valid_q <= 1'b0;
            latch_q       <= 1'b0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;

            if (done_q) begin
                pixel_data_q  <= shreg_q;
                pixel_valid_q <= 1'b1;
                if (pixel_count_q != 16'hFFFF)
                    pixel_count_q <= pixel_count_q + 16'd1;
            end

            if (!ena) begin
                state_q    <= IDLE;
                high_cnt_q <= '0;
                low_cnt_q  <= '0;
                bit_cnt_q  <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q    <= HIGH;
                            high_cnt_q <= CNT_W'(1);
                            if (clr_q) begin
                                pixel_count_q <= '0;
                                clr_q         <= 1'b0;
                            end
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            shreg_q   <= {shreg_q[22:0], bit_d};
                            low_cnt_q <= CNT_W'(1);
                            state_q   <= LOW;
                            if (bit_cnt_q == 5'd23) begin
                                bit_cnt_q <= '0;
                                done_q    <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end else if (high_cnt_q == CNT_W'(MAX_HIGH - 1)) begin
                            err_q     <= 1'b1;
                            bit_cnt_q <= '0;
                            low_cnt_q <= '0;
                            state_q   <= ERR_WAIT;
                        end else begin
                            high_cnt_q <= high_cnt_q + CNT_W'(1);
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            state_q    <= HIGH;
                            high_cnt_q <= CNT_W'(1);
                        end else if (low_cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                            latch_q   <= 1'b1;
                            err_q     <= (bit_cnt_q != '0);
                            bit_cnt_q <= '0;
                            clr_q     <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            low_cnt_q <= low_cnt_q + CNT_W'(1);
                        end
                    end
                    ERR_WAIT: begin
                        // any high sample restarts the quiet-time requirement
                        if (s2_q) begin
                            low_cnt_q <= '0;
                        end else if (low_cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                            state_q       <= IDLE;
                            low_cnt_q     <= '0;
                            bit_cnt_q     <= '0;
                            pixel_count_q <= '0;
                            clr_q         <= 1'b0;
                        end else begin
                            low_cnt_q <= low_cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_count = pixel_count_q;
    assign latch       = latch_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: waveform driver with an event-schedule model of the
// expected pixel/latch/err pulses, checked every cycle.
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        din = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [15:0] pixel_count;
    logic        latch;
    logic        err;

    ws2812_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .din         (din),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_count (pixel_count),
        .latch       (latch),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int lat_seen = 0;
    int err_seen = 0;
    int pv_seen = 0;

    // Expected events keyed by the cycle number they must appear in.
    bit          exp_pv[int];
    logic [23:0] exp_pd[int];
    int          exp_pc[int];
    bit          exp_lt[int];
    int          exp_lc[int];
    bit          exp_er[int];

    // Model of the frame as the line protocol defines it.
    int          m_bits, m_pix, m_tf;
    logic [23:0] m_sh;
    bit          m_new, m_inframe, m_errw, m_chk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_chk) begin
            chk("pixel_valid", 32'(pixel_valid), 32'(exp_pv.exists(cyc)));
            chk("latch", 32'(latch), 32'(exp_lt.exists(cyc)));
            chk("err", 32'(err), 32'(exp_er.exists(cyc)));
            if (exp_pv.exists(cyc)) begin
                chk("pixel_data", 32'(pixel_data), 32'(exp_pd[cyc]));
                chk("pixel_count", 32'(pixel_count), 32'(exp_pc[cyc]));
            end
            if (exp_lt.exists(cyc))
                chk("count_at_latch", 32'(pixel_count), 32'(exp_lc[cyc]));
            if (pixel_valid) pv_seen++;
            if (latch) lat_seen++;
            if (err) err_seen++;
        end
    end

    task automatic wait_cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_pv.delete(); exp_pd.delete(); exp_pc.delete();
        exp_lt.delete(); exp_lc.delete(); exp_er.delete();
        m_bits = 0; m_pix = 0; m_sh = '0; m_tf = 0;
        m_new = 1'b1; m_inframe = 1'b0; m_errw = 1'b0;
    endtask

    // One high pulse of h cycles followed by l low cycles (l well below a gap).
    task automatic pulse(int h, int l);
        int t0, tf;
        t0 = cyc;
        tf = t0 + h;
        if (h >= 100) begin
            if (!m_errw) exp_er[t0 + 102] = 1'b1;
            m_bits = 0;
            m_errw = 1'b1;
        end else if (!m_errw) begin
            if (m_new) begin
                m_pix = 0;
                m_new = 1'b0;
            end
            m_inframe = 1'b1;
            m_sh = {m_sh[22:0], (h >= 30)};
            m_bits++;
            if (m_bits == 24) begin
                m_bits = 0;
                if (m_pix < 65535) m_pix++;
                exp_pv[tf + 4] = 1'b1;
                exp_pd[tf + 4] = m_sh;
                exp_pc[tf + 4] = m_pix;
            end
        end
        din = 1'b1;
        wait_cyc(h);
        din = 1'b0;
        m_tf = tf;
        if (l > 0) wait_cyc(l);
    endtask

    // Extend the current low time by n cycles.
    task automatic gap(int n);
        int total;
        total = cyc + n - m_tf;
        if (total >= 2500) begin
            if (m_errw) begin
                m_errw = 1'b0;
                m_pix = 0;
                m_bits = 0;
                m_new = 1'b0;
                m_inframe = 1'b0;
            end else if (m_inframe) begin
                exp_lt[m_tf + 2502] = 1'b1;
                exp_lc[m_tf + 2502] = m_pix;
                if (m_bits != 0) exp_er[m_tf + 2502] = 1'b1;
                m_bits = 0;
                m_new = 1'b1;
                m_inframe = 1'b0;
            end
        end
        wait_cyc(n);
    endtask

    task automatic send_bit(bit b);
        if (b) pulse(40, 22);
        else pulse(20, 42);
    endtask

    task automatic send_pix(logic [23:0] v);
        for (int i = 23; i >= 0; i--) send_bit(v[i]);
    endtask

    initial begin
        model_clear();
        m_chk = 1'b0;
        rst_n = 1'b0;
        wait_cyc(3);
        chk("rst_pixel_data", 32'(pixel_data), 32'h0);
        chk("rst_pixel_valid", 32'(pixel_valid), 32'h0);
        chk("rst_pixel_count", 32'(pixel_count), 32'h0);
        chk("rst_latch", 32'(latch), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        wait_cyc(2);
        m_chk = 1'b1;

        // quiet line
        gap(3000);
        chk("t1_count", 32'(pixel_count), 32'h0);
        chk("t1_latches", 32'(lat_seen), 32'h0);

        // single pixel then latch
        send_pix(24'hA5C33C);
        gap(2600);
        chk("t2_data", 32'(pixel_data), 32'hA5C33C);
        chk("t2_count", 32'(pixel_count), 32'h1);
        chk("t2_latches", 32'(lat_seen), 32'h1);

        // three pixels back to back
        send_pix(24'hFF0000);
        send_pix(24'h00FF00);
        send_pix(24'h0000FF);
        gap(2600);
        chk("t3_data", 32'(pixel_data), 32'h0000FF);
        chk("t3_count", 32'(pixel_count), 32'h3);
        chk("t3_pixels", 32'(pv_seen), 32'h4);
        chk("t3_latches", 32'(lat_seen), 32'h2);

        // threshold boundary: 29 -> 0, 30 -> 1
        for (int i = 0; i < 12; i++) pulse(29, 42);
        for (int i = 0; i < 12; i++) pulse(30, 42);
        gap(2600);
        chk("t4_data", 32'(pixel_data), 32'h000FFF);

        // partial pixel then gap, then a clean frame
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        gap(2600);
        chk("t5_errs", 32'(err_seen), 32'h1);
        chk("t5_data_held", 32'(pixel_data), 32'h000FFF);
        send_pix(24'h5A5A5A);
        gap(2600);
        chk("t5_data", 32'(pixel_data), 32'h5A5A5A);
        chk("t5_count", 32'(pixel_count), 32'h1);

        // stuck-high line
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        pulse(150, 0);
        gap(2600);
        chk("t6_errs", 32'(err_seen), 32'h2);
        chk("t6_latches", 32'(lat_seen), 32'h5);
        chk("t6_count_clr", 32'(pixel_count), 32'h0);
        send_pix(24'h123456);
        gap(2600);
        chk("t6_data", 32'(pixel_data), 32'h123456);
        chk("t6_count", 32'(pixel_count), 32'h1);

        // reset in the middle of a pixel
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        din = 1'b1;
        wait_cyc(10);
        m_chk = 1'b0;
        rst_n = 1'b0;
        wait_cyc(1);
        chk("mid_rst_data", 32'(pixel_data), 32'h0);
        chk("mid_rst_count", 32'(pixel_count), 32'h0);
        chk("mid_rst_valid", 32'(pixel_valid), 32'h0);
        chk("mid_rst_latch", 32'(latch), 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        din = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(5);
        model_clear();
        m_chk = 1'b1;
        send_pix(24'h00C0DE);
        gap(2600);
        chk("post_rst_data", 32'(pixel_data), 32'h00C0DE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
